// File: rtl/screen_pkg.sv
// Shared definitions for the screen controller: screen encoding, keyboard
// scan codes, screen-ROM image layout and result-screen timing limits.
package screen_pkg;

  typedef enum logic [1:0] {
    StMenu   = 2'd0,
    StHelp   = 2'd1,
    StPlay   = 2'd2,
    StResult = 2'd3
  } screen_state_e;

  localparam logic [8:0] KEY_1     = 9'h016;
  localparam logic [8:0] KEY_2     = 9'h01E;
  localparam logic [8:0] KEY_3     = 9'h026;
  localparam logic [8:0] KEY_QMARK = 9'h04A;
  localparam logic [8:0] KEY_ESC   = 9'h076;

  // One 160x120 image per screen, stacked back to back in the ROM
  localparam logic [16:0] IMG_SIZE    = 17'd19200;
  localparam logic [16:0] IMG_SIZE_X2 = 17'd38400;
  localparam logic [16:0] OFFSET_MENU = 17'd0;
  localparam logic [16:0] OFFSET_HELP = 17'd19200;
  localparam logic [16:0] OFFSET_WIN  = 17'd38400;
  localparam logic [16:0] OFFSET_LOSE = 17'd57600;
  localparam logic [16:0] OFFSET_PLAY = 17'd0;

  // Result screen: keys ignored below MIN frames, auto-return at MAX frames
  localparam logic [7:0] RESULT_MIN = 8'd30;
  localparam logic [7:0] RESULT_MAX = 8'd180;

  // ROM image offset for the screen currently shown
  function automatic logic [16:0] img_offset(screen_state_e st, logic win);
    logic [16:0] off;
    case (st)
      StMenu:   off = OFFSET_MENU;
      StHelp:   off = OFFSET_HELP;
      StResult: off = win ? OFFSET_WIN : OFFSET_LOSE;
      default:  off = OFFSET_PLAY;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/screen_addr_gen.sv
// Combinational base address of the current VGA pixel inside one
// quarter-resolution (160x120) screen image.
module screen_addr_gen
  import screen_pkg::*;
(
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [16:0] base
);

  logic [16:0] h4;
  logic [16:0] v4;
  logic [16:0] raw;

  assign h4  = {7'd0, h_cnt} >> 2;
  assign v4  = {7'd0, v_cnt} >> 2;
  // 160*y as (y<<7)+(y<<5); raw stays below 3*IMG_SIZE for 10-bit counters
  assign raw = h4 + (v4 << 7) + (v4 << 5);

  // Reduce modulo IMG_SIZE with at most two conditional subtractions
  always_comb begin
    if (raw >= IMG_SIZE_X2) begin
      base = raw - IMG_SIZE_X2;
    end else if (raw >= IMG_SIZE) begin
      base = raw - IMG_SIZE;
    end else begin
      base = raw;
    end
  end

endmodule

// File: rtl/screen_ctrl.sv
// Screen controller: menu/help/play/result screen sequencing driven by
// keyboard events and the game core, plus the screen-ROM pixel address.
module screen_ctrl
  import screen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        keydown,
  input  logic        ready,
  input  logic [8:0]  last_change,
  input  logic        game_done,
  input  logic        game_win,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [1:0]  state,
  output logic [2:0]  level,
  output logic        game_start,
  output logic        game_en,
  output logic        rom_sel,
  output logic [16:0] pixel_addr
);

  screen_state_e state_q;
  logic [2:0]    level_q;
  logic          win_q;
  logic          game_start_q;
  logic [7:0]    frame_cnt_q;
  logic [7:0]    frame_cnt_inc;
  logic          keydown_q;
  logic          key_event;
  logic          frame_cmp;
  logic          frame_cmp_q;
  logic          frame_cmp_qq;
  logic          frame_tick;
  logic [16:0]   base;
  logic [16:0]   pixel_addr_q;

  screen_addr_gen u_addr_gen (
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .base  (base)
  );

  // Held keys must produce only one event, so qualify with the press edge
  assign key_event = keydown & ready & ~keydown_q;

  assign frame_cmp  = (v_cnt == 10'd480) && (h_cnt == 10'd0);
  assign frame_tick = frame_cmp_q & ~frame_cmp_qq;

  assign frame_cnt_inc = (frame_tick && (frame_cnt_q != 8'hFF)) ? frame_cnt_q + 8'd1
                                                               : frame_cnt_q;

  // Input edge detectors: key press and start-of-vertical-blank compare
  always_ff @(posedge clk) begin
    if (rst) begin
      keydown_q    <= 1'b0;
      frame_cmp_q  <= 1'b0;
      frame_cmp_qq <= 1'b0;
    end else begin
      keydown_q    <= keydown;
      frame_cmp_q  <= frame_cmp;
      frame_cmp_qq <= frame_cmp_q;
    end
  end

  // Screen FSM with registered level, win flag, frame counter and start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StMenu;
      level_q      <= 3'd0;
      win_q        <= 1'b0;
      frame_cnt_q  <= 8'd0;
      game_start_q <= 1'b0;
    end else begin
      game_start_q <= 1'b0;
      frame_cnt_q  <= frame_cnt_inc;
      case (state_q)
        StMenu: begin
          if (key_event) begin
            case (last_change)
              KEY_1: begin
                state_q      <= StPlay;
                level_q      <= 3'd1;
                game_start_q <= 1'b1;
              end
              KEY_2: begin
                state_q      <= StPlay;
                level_q      <= 3'd2;
                game_start_q <= 1'b1;
              end
              KEY_3: begin
                state_q      <= StPlay;
                level_q      <= 3'd3;
                game_start_q <= 1'b1;
              end
              KEY_QMARK: state_q <= StHelp;
              default: ;
            endcase
          end
        end
        StHelp: begin
          if (key_event && (last_change == KEY_ESC || last_change == KEY_QMARK)) begin
            state_q <= StMenu;
          end
        end
        StPlay: begin
          // A finished round outranks a simultaneous ESC
          if (game_done) begin
            state_q     <= StResult;
            win_q       <= game_win;
            frame_cnt_q <= 8'd0;
          end else if (key_event && last_change == KEY_ESC) begin
            state_q <= StMenu;
            level_q <= 3'd0;
          end
        end
        StResult: begin
          if ((frame_cnt_inc >= RESULT_MAX) || (key_event && frame_cnt_q >= RESULT_MIN)) begin
            state_q <= StMenu;
            level_q <= 3'd0;
          end
        end
        default: state_q <= StMenu;
      endcase
    end
  end

  // Screen-ROM address, one clock behind the pixel counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr_q <= 17'd0;
    end else begin
      pixel_addr_q <= base + img_offset(state_q, win_q);
    end
  end

  assign state      = state_q;
  assign level      = level_q;
  assign game_start = game_start_q;
  assign game_en    = (state_q == StPlay);
  assign rom_sel    = (state_q != StPlay);
  assign pixel_addr = pixel_addr_q;

endmodule

// File: tb/tb_screen_ctrl.sv
// Self-checking bench for screen_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic, all against a behavioural model.
module tb_screen_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        keydown;
  logic        ready;
  logic [8:0]  last_change;
  logic        game_done;
  logic        game_win;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [1:0]  state;
  logic [2:0]  level;
  logic        game_start;
  logic        game_en;
  logic        rom_sel;
  logic [16:0] pixel_addr;

  always #5 clk = ~clk;

  screen_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .keydown     (keydown),
    .ready       (ready),
    .last_change (last_change),
    .game_done   (game_done),
    .game_win    (game_win),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .state       (state),
    .level       (level),
    .game_start  (game_start),
    .game_en     (game_en),
    .rom_sel     (rom_sel),
    .pixel_addr  (pixel_addr)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: screens 0=menu 1=help 2=play 3=result
  int m_st, m_lvl, m_win, m_fc, m_start, m_addr;
  bit m_kd, m_c1, m_c2;

  function automatic int base_of(int h, int v);
    return ((h / 4) + 160 * (v / 4)) % 19200;
  endfunction

  function automatic int offset_of(int st, int win);
    if (st == 1) return 19200;
    if (st == 3) return win ? 38400 : 57600;
    return 0;
  endfunction

  task automatic model_edge();
    int nst, nlvl, nfc;
    bit ev, tick;
    if (rst) begin
      m_st = 0; m_lvl = 0; m_win = 0; m_fc = 0; m_start = 0; m_addr = 0;
      m_kd = 0; m_c1 = 0; m_c2 = 0;
      return;
    end
    ev   = keydown && ready && !m_kd;
    tick = m_c1 && !m_c2;  // rising edge of the frame compare, seen one clock late
    nfc  = tick ? ((m_fc < 255) ? m_fc + 1 : 255) : m_fc;
    nst  = m_st;
    nlvl = m_lvl;
    m_addr = base_of(int'(h_cnt), int'(v_cnt)) + offset_of(m_st, m_win);
    case (m_st)
      0: if (ev) begin
        if (last_change == 9'h016) begin nst = 2; nlvl = 1; end
        else if (last_change == 9'h01E) begin nst = 2; nlvl = 2; end
        else if (last_change == 9'h026) begin nst = 2; nlvl = 3; end
        else if (last_change == 9'h04A) nst = 1;
      end
      1: if (ev && (last_change == 9'h076 || last_change == 9'h04A)) nst = 0;
      2: if (game_done) begin
        nst = 3; m_win = game_win; nfc = 0;
      end else if (ev && last_change == 9'h076) begin
        nst = 0; nlvl = 0;
      end
      default: if (nfc >= 180 || (ev && m_fc >= 30)) begin nst = 0; nlvl = 0; end
    endcase
    m_start = (nst == 2 && m_st != 2) ? 1 : 0;
    m_st = nst;
    m_lvl = nlvl;
    m_fc = nfc;
    m_kd = keydown;
    m_c2 = m_c1;
    m_c1 = (v_cnt == 10'd480 && h_cnt == 10'd0);
  endtask

  task automatic check_model();
    logic [24:0] act, exp;
    act = {state, level, game_start, game_en, rom_sel, pixel_addr};
    exp = {2'(m_st), 3'(m_lvl), 1'(m_start), m_st == 2, m_st != 2, 17'(m_addr)};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model t=%0t: got st=%0d lvl=%0d gs=%0b en=%0b rom=%0b addr=%0d, want st=%0d lvl=%0d gs=%0d addr=%0d",
               $time, state, level, game_start, game_en, rom_sel, pixel_addr,
               m_st, m_lvl, m_start, m_addr);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      v_cnt = 10'd480; h_cnt = 10'd0;
      repeat (4) step();
      v_cnt = 10'd0;
      repeat (4) step();
    end
  endtask

  typedef struct {
    bit         kd;
    bit         rdy;
    logic [8:0] code;
    bit         done;
    bit         win;
    int         h;
    int         v;
    int         st;
    int         lvl;
    int         gs;
    int         addr;  // -1: not checked
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit kd, bit rdy, logic [8:0] code, bit done, bit win, int h, int v,
                     int st, int lvl, int gs, int addr);
    vec_t r;
    r.kd = kd; r.rdy = rdy; r.code = code; r.done = done; r.win = win; r.h = h; r.v = v;
    r.st = st; r.lvl = lvl; r.gs = gs; r.addr = addr;
    vecs.push_back(r);
  endtask

  initial begin
    int hold;
    rst = 1'b1; keydown = 1'b0; ready = 1'b0; last_change = 9'h0;
    game_done = 1'b0; game_win = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;

    // Reset values
    step();
    step();
    chk("reset_state", 32'(state), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_rom_sel", 32'(rom_sel), 1);
    chk("reset_game_en", 32'(game_en), 0);
    chk("reset_addr", 32'(pixel_addr), 0);
    rst = 1'b0;

    // KEY_2 held 10 clocks, then menu/help navigation and a done+ESC collision
    add(1, 1, 9'h01E, 0, 0, 0, 0, 2, 2, 1, 0);
    for (int i = 0; i < 9; i++) add(1, 1, 9'h01E, 0, 0, 0, 0, 2, 2, 0, 0);
    add(0, 1, 9'h01E, 0, 0, 0, 0, 2, 2, 0, 0);
    add(1, 1, 9'h076, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 9'h076, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 9'h04A, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 9'h04A, 0, 0, 8, 4, 1, 0, 0, 19362);
    add(1, 1, 9'h076, 0, 0, 8, 4, 0, 0, 0, 19362);
    add(0, 1, 9'h076, 0, 0, 8, 4, 0, 0, 0, 162);
    add(1, 1, 9'h01C, 0, 0, 8, 4, 0, 0, 0, 162);
    add(0, 1, 9'h01C, 0, 0, 8, 4, 0, 0, 0, -1);
    add(1, 0, 9'h016, 0, 0, 8, 4, 0, 0, 0, -1);
    add(1, 1, 9'h016, 0, 0, 8, 4, 0, 0, 0, -1);
    add(0, 1, 9'h016, 0, 0, 8, 4, 0, 0, 0, -1);
    add(1, 1, 9'h026, 0, 0, 8, 4, 2, 3, 1, 162);
    add(0, 1, 9'h026, 0, 0, 8, 4, 2, 3, 0, 162);
    add(1, 1, 9'h076, 1, 0, 8, 4, 3, 3, 0, 162);
    add(0, 1, 9'h076, 0, 0, 8, 4, 3, 3, 0, 57762);

    foreach (vecs[i]) begin
      keydown = vecs[i].kd; ready = vecs[i].rdy; last_change = vecs[i].code;
      game_done = vecs[i].done; game_win = vecs[i].win;
      h_cnt = 10'(vecs[i].h); v_cnt = 10'(vecs[i].v);
      step();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_start", i), 32'(game_start), 32'(vecs[i].gs));
      if (vecs[i].addr >= 0) chk($sformatf("vec%0d_addr", i), 32'(pixel_addr), 32'(vecs[i].addr));
    end
    game_done = 1'b0;
    h_cnt = 10'd0; v_cnt = 10'd0;

    // Result screen: early key ignored, later key accepted
    frames(10);
    keydown = 1'b1; ready = 1'b1; last_change = 9'h01C;
    step();
    chk("result_key_frame10", 32'(state), 3);
    keydown = 1'b0;
    step();
    frames(30);
    keydown = 1'b1;
    step();
    chk("result_key_frame40_state", 32'(state), 0);
    chk("result_key_frame40_level", 32'(level), 0);
    keydown = 1'b0;
    step();

    // Result screen timeout after 180 frames (win image)
    keydown = 1'b1; last_change = 9'h016;
    step();
    keydown = 1'b0;
    step();
    game_done = 1'b1; game_win = 1'b1;
    step();
    chk("win_enter_result", 32'(state), 3);
    game_done = 1'b0; game_win = 1'b0;
    step();
    chk("win_addr_offset", 32'(pixel_addr), 38400);
    frames(179);
    chk("timeout_frame179", 32'(state), 3);
    v_cnt = 10'd480;
    step();
    chk("timeout_before_tick", 32'(state), 3);
    step();
    chk("timeout_after_tick180", 32'(state), 0);
    v_cnt = 10'd0;
    repeat (4) step();

    // Reset mid-play with a same-cycle game_done, then reset vs. a start key
    keydown = 1'b1; last_change = 9'h016;
    step();
    chk("play_before_rst", 32'(game_en), 1);
    keydown = 1'b0;
    step();
    rst = 1'b1; game_done = 1'b1;
    step();
    chk("rst_play_state", 32'(state), 0);
    chk("rst_play_level", 32'(level), 0);
    chk("rst_play_en", 32'(game_en), 0);
    chk("rst_play_rom", 32'(rom_sel), 1);
    game_done = 1'b0; keydown = 1'b1; last_change = 9'h026;
    step();
    chk("rst_vs_key_start", 32'(game_start), 0);
    chk("rst_vs_key_state", 32'(state), 0);
    rst = 1'b0; keydown = 1'b0;
    step();

    // Randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        keydown = ~keydown;
        if (keydown) begin
          case ($urandom_range(0, 5))
            0: last_change = 9'h016;
            1: last_change = 9'h01E;
            2: last_change = 9'h026;
            3: last_change = 9'h04A;
            4: last_change = 9'h076;
            default: last_change = 9'($urandom);
          endcase
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      game_done = ($urandom_range(0, 19) == 0);
      game_win = 1'($urandom);
      if (hold == 0) begin
        hold = $urandom_range(4, 8);
        if ($urandom_range(0, 2) == 0) begin
          h_cnt = 10'd0; v_cnt = 10'd480;
        end else begin
          h_cnt = 10'($urandom_range(0, 1023));
          v_cnt = 10'($urandom_range(0, 1023));
        end
      end
      hold--;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/screen_ctrl.md
SCREEN_CTRL -- requirements
Module: screen_ctrl

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock, 100 MHz.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 keydown  in  1  keyboard decoder: key currently held.
REQ-005 ready  in  1  keyboard decoder: last_change is valid.
REQ-006 last_change  in  9  scan code of the most recent key.
REQ-007 game_done  in  1  one-cycle pulse from the game core: round finished.
REQ-008 game_win  in  1  win flag from the game core; sampled only when game_done=1.
REQ-009 h_cnt, v_cnt  in  10 each  VGA pixel counters (25 MHz domain, slow-changing, stable for ≥4 clk).
REQ-010 state  out  2  current screen: MENU=0, HELP=1, PLAY=2, RESULT=3.
REQ-011 level  out  3  selected level: 0=none, 1..3.
REQ-012 game_start  out  1  one-cycle pulse on the cycle state becomes PLAY.
REQ-013 game_en  out  1  high while state==PLAY.
REQ-014 rom_sel  out  1  high when VGA pixels come from the screen ROM (state!=PLAY).
REQ-015 pixel_addr  out  17  screen-ROM address.

Function
REQ-016 key_event = keydown & ready & ~keydown_q, where keydown_q is keydown delayed one clk; a held key produces exactly one event.
REQ-017 Scan codes: KEY_1=9'h016, KEY_2=9'h01E, KEY_3=9'h026, KEY_QMARK=9'h04A, KEY_ESC=9'h076.
REQ-018 MENU: event KEY_1/2/3 -> PLAY with level=1/2/3 and game_start=1; event KEY_QMARK -> HELP; other keys are ignored.
REQ-019 HELP: event KEY_ESC or KEY_QMARK -> MENU; level is unchanged (0).
REQ-020 PLAY: game_done -> RESULT, latching win_q=game_win; event KEY_ESC -> MENU with level=0.
REQ-021 PLAY priority: when game_done and an ESC event occur in the same cycle, game_done wins.
REQ-022 RESULT: any key event, or frame_cnt reaching 180 -> MENU with level=0.
REQ-023 RESULT: key events are ignored until frame_cnt ≥ 30, which blocks accidental skips.
REQ-024 frame_tick: one-cycle pulse on the rising edge of (v_cnt==480 && h_cnt==0), edge-detected with a registered compare.
REQ-025 frame_cnt: 8-bit counter, cleared on entry to RESULT, increments on frame_tick, saturates at 255.
REQ-026 Image base: ((h_cnt>>2) + 160*(v_cnt>>2)) mod 19200.
REQ-027 pixel_addr = base + offset, registered with 1-clk latency.
REQ-028 Offsets: MENU=0; HELP=19200; RESULT win=38400; RESULT lose=57600; PLAY holds 0.
REQ-029 Arithmetic: sums are computed 17-bit wide; the maximum address is 76799, and addresses never exceed 76799.
REQ-030 game_start is never asserted in two consecutive cycles.
REQ-031 State updates only on clk edges; outputs state, level, game_en and rom_sel are registered or decoded directly from registered state.

Reset
REQ-032 On rst: state=MENU, level=0, game_start=0, game_en=0, rom_sel=1, pixel_addr=0, win_q=0, frame_cnt=0, keydown_q=0.
REQ-033 rst asserted in any state, including mid-PLAY, forces REQ-032 on the next edge; no game_start is emitted.
REQ-034 rst has priority over every input event in the same cycle.

Structure
REQ-035 Shared package screen_pkg holds: state encoding, scan-code constants, image offsets, IMG_SIZE=19200, RESULT_MIN=30, RESULT_MAX=180.
REQ-036 One sub-module, screen_addr_gen, computes the base address of REQ-026 combinationally; the registered offset add stays in screen_ctrl.
REQ-037 The ROM instance and the pixel mux live outside this block; this block drives only rom_sel and pixel_addr.

Verification
REQ-038 Reset, then a KEY_2 press held 10 clk -> state=PLAY, level=2, exactly one game_start pulse, game_en=1.
REQ-039 From MENU: KEY_QMARK press -> HELP; h_cnt=8, v_cnt=4 -> pixel_addr=19200+2+160=19362 one clk later; KEY_ESC -> MENU.
REQ-040 PLAY level 3: game_done=1 with game_win=0, same cycle as an ESC event -> RESULT; pixel_addr offset 57600.
REQ-041 RESULT: key at frame 10 -> stays RESULT; key at frame 40 -> MENU, level=0.
REQ-042 RESULT with no keys -> MENU exactly on the clock after frame_tick 180.
REQ-043 rst pulse mid-PLAY -> next cycle state=MENU, level=0, game_en=0, rom_sel=1.
